// File: rtl/shift_seq_unit_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the sequential shifter slice: default widths,
// the 2-bit shift operation codes and the controller state encoding.
// No ports; imported by shift_seq_unit_if, shift_step and shift_seq_unit.
// ---------------------------------------------------------------------------
package shift_pkg;

   // Default operand width and shift-amount width.
   localparam int SSU_DATA_W  = 32;
   localparam int SSU_SHAMT_W = 5;

   // Shift operation codes as driven on the op input.
   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_seq_unit_if.sv
// ---------------------------------------------------------------------------
// shift_seq_unit_if
// Request/response bundle between the datapath control and the shifter.
//   start    request strobe, only looked at while the shifter is idle
//   op       SLL / SRL / SRA / PASS
//   shamt    shift amount from the shift-amount select mux
//   data_in  operand
//   busy     shifter is stepping
//   done     one-cycle pulse, result is valid
//   result   shifted value, held until the next accepted request completes
// master = requester (control / bench), slave = shifter.
// ---------------------------------------------------------------------------
interface shift_seq_unit_if
   import shift_pkg::*;
#(
   parameter int DATA_W  = SSU_DATA_W,
   parameter int SHAMT_W = SSU_SHAMT_W
);

   logic               start;
   logic [1:0]         op;
   logic [SHAMT_W-1:0] shamt;
   logic [DATA_W-1:0]  data_in;
   logic               busy;
   logic               done;
   logic [DATA_W-1:0]  result;

   modport master (
      output start, op, shamt, data_in,
      input  busy, done, result
   );

   modport slave (
      input  start, op, shamt, data_in,
      output busy, done, result
   );

endinterface

// File: rtl/shift_seq_unit_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational single-position shift of the working register.
//   i_op    operation latched at request time
//   i_data  current working value
//   o_data  value shifted by one position (unchanged for PASS)
// ---------------------------------------------------------------------------
module shift_step
   import shift_pkg::*;
#(
   parameter int DATA_W = SSU_DATA_W
) (
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   // One bit per clock; SRA replicates the sign bit into the vacated MSB.
   always_comb begin
      o_data = i_data;
      case (i_op)
         OP_SLL:  o_data = {i_data[DATA_W-2:0], 1'b0};
         OP_SRL:  o_data = {1'b0, i_data[DATA_W-1:1]};
         OP_SRA:  o_data = {i_data[DATA_W-1], i_data[DATA_W-1:1]};
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/shift_seq_unit.sv
// ---------------------------------------------------------------------------
// shift_seq_unit
// Multicycle shifter that sits beside the ALU: takes an operand and a shift
// amount and shifts one bit position per clock under start/busy/done.
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation without a done
//   bus    shift_seq_unit_if slave modport (start/op/shamt/data_in in,
//          busy/done/result out)
// A request with shamt==0 or op==PASS completes one cycle after acceptance;
// otherwise the unit spends shamt cycles in SHIFT and then one in DONE.
// ---------------------------------------------------------------------------
module shift_seq_unit
   import shift_pkg::*;
#(
   parameter int DATA_W  = SSU_DATA_W,
   parameter int SHAMT_W = SSU_SHAMT_W
) (
   input  logic              clk,
   input  logic              reset,
   shift_seq_unit_if.slave   bus
);

   state_t             r_state;
   logic [DATA_W-1:0]  r_sreg;
   logic [SHAMT_W-1:0] r_count;
   logic [1:0]         r_opQ;
   logic               r_busy;
   logic               r_done;
   logic [DATA_W-1:0]  r_result;
   logic [DATA_W-1:0]  w_shifted;

   shift_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .i_op   (r_opQ),
      .i_data (r_sreg),
      .o_data (w_shifted)
   );

   // Controller, working register and outputs in one registered block.
   // busy/done/result are set on the edge that enters the corresponding
   // state so they are clean registered outputs. The request fields are
   // copied at acceptance, so later changes on the bus have no effect, and
   // start is only examined in IDLE, so re-requests are simply dropped.
   // count stops at 1: the edge that sees count==1 performs the final shift
   // and moves to DONE instead of decrementing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_sreg   <= '0;
         r_count  <= '0;
         r_opQ    <= OP_SLL;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_sreg  <= bus.data_in;
                  r_opQ   <= bus.op;
                  r_count <= bus.shamt;
                  if ((bus.shamt == '0) || (bus.op == OP_PASS)) begin
                     r_state  <= DONE;
                     r_done   <= 1'b1;
                     r_result <= bus.data_in;
                  end else begin
                     r_state <= SHIFT;
                     r_busy  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               r_sreg <= w_shifted;
               if (r_count == SHAMT_W'(1)) begin
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_result <= w_shifted;
               end else begin
                  r_count <= r_count - SHAMT_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule

// File: tb/tb_shift_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_unit
// Directed scoreboard bench for shift_seq_unit. Each issued request pushes
// its hand-computed result, start-to-done latency and busy-cycle count; a
// monitor pops an entry on every done pulse and compares.
// ---------------------------------------------------------------------------
module tb_shift_seq_unit;
   import shift_pkg::*;

   typedef struct {
      logic [31:0] result;
      int          latency;
      int          busyCycles;
      int          acceptCycle;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails = 0;
   int   cycleCnt = 0;
   int   busyCnt = 0;
   int   doneCount = 0;
   int   pushCount = 0;
   exp_t sbQ[$];

   shift_seq_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

   shift_seq_unit #(
      .DATA_W  (32),
      .SHAMT_W (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock and cycle counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // One comparison: count it, report a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles and scores each done pulse against the queue.
   always @(negedge clk) begin
      if (reset) begin
         busyCnt = 0;
      end else begin
         if (bus.busy) busyCnt++;
         if (bus.done) begin
            exp_t e;
            doneCount++;
            if (sbQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_done: got done with result 0x%08h, expected no done", bus.result);
            end else begin
               e = sbQ.pop_front();
               checkOutput("result", bus.result, e.result);
               checkOutput("latency", 32'(cycleCnt - e.acceptCycle), 32'(e.latency));
               checkOutput("busy_cycles", 32'(busyCnt), 32'(e.busyCycles));
            end
            busyCnt = 0;
         end
      end
   end

   // Drive one request at a falling edge, optionally registering its expected
   // response; inputs are scrambled right after acceptance.
   task automatic applyStimulus(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                                input logic [31:0] expRes, input int expLat, input int expBusy,
                                input bit doPush);
      exp_t e;
      bus.start   = 1'b1;
      bus.op      = op;
      bus.shamt   = sh;
      bus.data_in = d;
      if (doPush) begin
         e.result      = expRes;
         e.latency     = expLat;
         e.busyCycles  = expBusy;
         e.acceptCycle = cycleCnt;
         sbQ.push_back(e);
         pushCount++;
      end
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.op      = 2'($urandom_range(0, 3));
      bus.shamt   = 5'($urandom_range(0, 31));
      bus.data_in = $urandom;
      @(negedge clk);
   endtask

   // Wait (bounded) for all outstanding responses, then one more cycle so
   // the unit is back in IDLE.
   task automatic waitDrain();
      for (int i = 0; i < 200 && sbQ.size() != 0; i++) @(negedge clk);
      if (sbQ.size() != 0) begin
         checks++;
         fails++;
         $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sbQ.size());
         sbQ.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.op      = OP_SLL;
      bus.shamt   = '0;
      bus.data_in = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_result", bus.result, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] SLL by 4");
      applyStimulus(OP_SLL, 5'd4, 32'h0000_0001, 32'h0000_0010, 5, 4, 1'b1);
      waitDrain();
      repeat (2) @(negedge clk);
      checkOutput("result_hold", bus.result, 32'h0000_0010);

      $display("[TB] SRA by 31");
      applyStimulus(OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32, 31, 1'b1);
      waitDrain();

      $display("[TB] SRL by 16");
      applyStimulus(OP_SRL, 5'd16, 32'h8000_0000, 32'h0000_8000, 17, 16, 1'b1);
      waitDrain();

      $display("[TB] zero shift and PASS");
      applyStimulus(OP_SLL, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1'b1);
      waitDrain();
      applyStimulus(OP_PASS, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1'b1);
      waitDrain();

      $display("[TB] misc patterns");
      applyStimulus(OP_SRA, 5'd4, 32'h7FFF_0000, 32'h07FF_F000, 5, 4, 1'b1);
      waitDrain();
      applyStimulus(OP_SRA, 5'd4, 32'h8000_0010, 32'hF800_0001, 5, 4, 1'b1);
      waitDrain();
      applyStimulus(OP_SLL, 5'd1, 32'h8000_0001, 32'h0000_0002, 2, 1, 1'b1);
      waitDrain();

      $display("[TB] start re-pulsed mid-SHIFT");
      applyStimulus(OP_SRL, 5'd8, 32'hF000_0000, 32'h00F0_0000, 9, 8, 1'b1);
      repeat (3) @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = OP_SLL;
      bus.shamt   = 5'd1;
      bus.data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.start = 1'b0;
      waitDrain();
      repeat (3) @(negedge clk);

      $display("[TB] reset mid-SHIFT");
      applyStimulus(OP_SLL, 5'd10, 32'h0000_0001, 32'h0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_done", 32'(bus.done), 32'd0);
      checkOutput("abort_result", bus.result, 32'h0);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      applyStimulus(OP_SRL, 5'd8, 32'h0000_0100, 32'h0000_0001, 9, 8, 1'b1);
      waitDrain();
      repeat (3) @(negedge clk);

      checkOutput("done_count", 32'(doneCount), 32'(pushCount));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
